seq_detect_prog: RTL and testbench

Parametrised, run-time programmable serial bit-pattern detector; the next generation of the team's fixed 101 detector. Accepts a qualified serial bit stream and detects any pattern up to MAX_LEN bits, in overlapping or non-overlapping mode. Emits a registered match pulse and keeps a saturating match counter. Out of reset it behaves as an overlapping 101 detector, so existing benches and coverage carry over.

---
 rtl/seq_detect_prog.sv | 87 ++++++++
 tb/tb_seq_detect_prog.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: run-time programmable serial pattern detector.
// A shift register holds the most recent accepted bits. A fill counter tracks
// how many of them belong to the current match attempt, so it acts as the
// detector state. The match pulse and the saturating counter are registered.
module seq_detect_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 16,
  parameter logic [MAX_LEN-1:0] RST_PAT = 'b101,
  parameter int                 RST_LEN = 3,
  parameter int                 LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_cnt,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_ovf
);

  logic [MAX_LEN-1:0] pat, hist, hist_n, mask;
  logic [LEN_W-1:0]   len, fill, fill_inc, len_ld;
  logic               ovl, hit, hit_acc;

  // Clamp the requested length into 1..MAX_LEN before it is stored
  always_comb begin
    len_ld = cfg_len;
    if (cfg_len == '0)                     len_ld = LEN_W'(1);
    else if (cfg_len > LEN_W'(MAX_LEN))    len_ld = LEN_W'(MAX_LEN);
  end

  // Next history/fill and hit detection; bits at or above len are masked off
  always_comb begin
    hist_n   = {hist[MAX_LEN-2:0], in_bit};
    fill_inc = (fill >= len) ? len : fill + LEN_W'(1);
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (LEN_W'(i) < len);
    hit      = (fill_inc == len) && (((hist_n ^ pat) & mask) == '0);
    hit_acc  = in_valid && !cfg_load && hit;
  end

  // Pattern config, history, fill and the one-cycle match pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat   <= RST_PAT;
      len   <= LEN_W'(RST_LEN);
      ovl   <= 1'b1;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= 1'b0;
      if (cfg_load) begin
        // a new config restarts matching; a bit offered this cycle is dropped
        pat  <= cfg_pattern;
        len  <= len_ld;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
      end else if (in_valid) begin
        hist  <= hist_n;
        // non-overlap: the next match needs len fresh bits
        fill  <= (hit && !ovl) ? '0 : fill_inc;
        match <= hit;
      end
    end
  end

  // Saturating match counter with sticky overflow; clear beats a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      cnt_ovf   <= 1'b0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
      cnt_ovf   <= 1'b0;
    end else if (hit_acc) begin
      if (&match_cnt) cnt_ovf   <= 1'b1;
      else            match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios plus a random stream, all
// checked against a window-of-bits reference model kept in the bench.
module tb_seq_detect_prog;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 0, rst_n = 0;
  logic               cfg_load = 0, cfg_overlap = 0, in_valid = 0, in_bit = 0, clr_cnt = 0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               match, cnt_ovf;
  logic [CNT_W-1:0]   match_cnt;

  int checks = 0, failures = 0;

  // reference model: bits accepted since last restart, plus config and outputs
  bit               win[$];
  bit [MAX_LEN-1:0] mpat;
  int               mlen;
  bit               movl;
  bit               exp_match, exp_ovf;
  int               exp_cnt;

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in_bit(in_bit), .clr_cnt(clr_cnt), .match(match), .match_cnt(match_cnt),
    .cnt_ovf(cnt_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    win.delete();
    mpat = MAX_LEN'(5); mlen = 3; movl = 1;
    exp_match = 0; exp_cnt = 0; exp_ovf = 0;
  endtask

  // advance the model by one rising edge using the inputs the DUT sampled
  task automatic model_edge();
    bit hit;
    int l;
    hit = 0;
    exp_match = 0;
    if (cfg_load) begin
      l = int'(cfg_len);
      if (l == 0) l = 1;
      if (l > MAX_LEN) l = MAX_LEN;
      mpat = cfg_pattern; mlen = l; movl = cfg_overlap;
      win.delete();
    end else if (in_valid) begin
      win.push_back(in_bit);
      if (win.size() > MAX_LEN) void'(win.pop_front());
      if (win.size() >= mlen) begin
        hit = 1;
        for (int i = 0; i < mlen; i++)
          if (win[win.size()-1-i] != mpat[i]) hit = 0;
      end
      exp_match = hit;
      if (hit && !movl) win.delete();
    end
    if (clr_cnt) begin
      exp_cnt = 0; exp_ovf = 0;
    end else if (hit) begin
      if (exp_cnt == CMAX) exp_ovf = 1;
      else exp_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit v, input bit b);
    cfg_load = 0; clr_cnt = 0; in_valid = v; in_bit = b;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o);
    cfg_load = 1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    in_valid = 1; in_bit = $urandom_range(0, 1);
    tick();
    cfg_load = 0; in_valid = 0;
  endtask

  task automatic clear_count();
    drive(0, 0); clr_cnt = 1; tick(); clr_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    #1;
    checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%0b exp=0", match); end
    checks++; if (match_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
    checks++; if (cnt_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", cnt_ovf); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_overlap_101();
    bit bits [5] = '{1, 0, 1, 0, 1};
    bit want [5] = '{0, 0, 1, 0, 1};
    foreach (bits[i]) begin
      drive(1, bits[i]); tick();
      checks++;
      if (match !== want[i] || match !== exp_match) begin
        failures++; $display("FAIL ovl101_match bit%0d got=%0b exp=%0b", i+1, match, want[i]);
      end
    end
    drive(0, 0); tick();
    checks++; if (match_cnt !== 2'd2) begin failures++; $display("FAIL ovl101_cnt got=%0d exp=2", match_cnt); end
  endtask

  task automatic test_non_overlap();
    bit bits [5] = '{1, 0, 1, 0, 1};
    int pulses = 0;
    clear_count();
    load(8'b101, 3, 0);
    foreach (bits[i]) begin
      drive(1, bits[i]); tick();
      pulses += match;
      checks++; if (match !== exp_match) begin failures++; $display("FAIL novl_match bit%0d got=%0b exp=%0b", i+1, match, exp_match); end
    end
    drive(0, 0); tick();
    checks++; if (pulses != 1 || match_cnt !== 2'd1) begin failures++; $display("FAIL novl_cnt got=%0d pulses=%0d exp=1", match_cnt, pulses); end
  endtask

  task automatic test_max_len_gaps();
    logic [7:0] p = 8'b1100_1010;
    int pulses = 0, n = 0;
    clear_count();
    load(p, 8, 1);
    while (n < 8) begin
      if (n == 4 && pulses >= 0) begin
        for (int g = 0; g < 2; g++) begin
          drive(0, $urandom_range(0, 1)); tick();
          pulses += match;
          checks++; if (match !== 1'b0) begin failures++; $display("FAIL gap_pulse got=%0b exp=0", match); end
        end
      end
      drive(1, p[7-n]); tick(); n++;
      pulses += match;
      checks++;
      if (match !== (n == 8) || match !== exp_match) begin
        failures++; $display("FAIL maxlen_match bit%0d got=%0b exp=%0b", n, match, (n == 8));
      end
    end
    drive(0, 0); tick();
    checks++; if (pulses != 1) begin failures++; $display("FAIL maxlen_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_clamp();
    bit bits [4] = '{1, 1, 0, 1};
    int pulses = 0;
    clear_count();
    load(8'b1, 0, 1);
    foreach (bits[i]) begin
      drive(1, bits[i]); tick();
      pulses += match;
      checks++; if (match !== bits[i] || match !== exp_match) begin failures++; $display("FAIL len1_match bit%0d got=%0b exp=%0b", i, match, bits[i]); end
    end
    checks++; if (pulses != 3) begin failures++; $display("FAIL len1_pulses got=%0d exp=3", pulses); end
    load(8'hFF, 15, 1);
    checks++; if (dut.len !== LEN_W'(8)) begin failures++; $display("FAIL len_clamp got=%0d exp=8", dut.len); end
    for (int i = 0; i < 8; i++) begin
      drive(1, 1); tick();
      checks++; if (match !== (i == 7) || match !== exp_match) begin failures++; $display("FAIL len8_match bit%0d got=%0b exp=%0b", i+1, match, (i == 7)); end
    end
  endtask

  task automatic test_saturation();
    clear_count();
    load(8'b1, 1, 1);
    for (int i = 0; i < 4; i++) begin drive(1, 1); tick(); end
    checks++; if (match_cnt !== 2'd3 || match_cnt !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL sat_cnt got=%0d exp=3", match_cnt); end
    checks++; if (cnt_ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%0b exp=1", cnt_ovf); end
    drive(1, 1); clr_cnt = 1; tick(); clr_cnt = 0;
    checks++; if (match_cnt !== 2'd0 || cnt_ovf !== 1'b0) begin failures++; $display("FAIL clr_hit got cnt=%0d ovf=%0b exp 0/0", match_cnt, cnt_ovf); end
    checks++; if (match !== 1'b1) begin failures++; $display("FAIL clr_hit_match got=%0b exp=1", match); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    drive(1, 1); tick();
    drive(1, 0); tick();
    rst_n = 0; model_reset();
    #1;
    checks++; if (match !== 1'b0 || match_cnt !== '0) begin failures++; $display("FAIL midrst_out got match=%0b cnt=%0d exp 0/0", match, match_cnt); end
    drive(1, 1);
    @(posedge clk); #1;
    checks++; if (match !== 1'b0 || match_cnt !== '0) begin failures++; $display("FAIL midrst_hold got match=%0b cnt=%0d exp 0/0", match, match_cnt); end
    rst_n = 1;
    tick();
    pulses += match;
    drive(0, 0); tick();
    pulses += match;
    checks++; if (pulses != 0 || exp_match) begin failures++; $display("FAIL midrst_match got pulses=%0d exp=0", pulses); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1));
      clr_cnt = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 60) == 0) begin
        cfg_load = 1;
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len = LEN_W'($urandom_range(0, 15));
        cfg_overlap = $urandom_range(0, 1);
      end
      tick();
      checks++;
      if (match !== exp_match || match_cnt !== CNT_W'(exp_cnt) || cnt_ovf !== exp_ovf) begin
        failures++; errs++;
        if (errs < 10)
          $display("FAIL rand_cyc%0d got m=%0b c=%0d o=%0b exp m=%0b c=%0d o=%0b",
                   c, match, match_cnt, cnt_ovf, exp_match, exp_cnt, exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap_101();
    test_non_overlap();
    test_max_len_gaps();
    test_clamp();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
